pipe_ctrl_backend: RTL and testbench

//  Consumer side of the decode-stage control bundle in the 5-stage RV32I pipeline. Takes the D-stage

---
 rtl/pipe_ctrl_backend_pkg.sv | 61 ++++++
 rtl/pipe_ctrl_backend_hazard_unit.sv | 41 ++++
 rtl/pipe_ctrl_backend.sv | 94 +++++++++
 tb/tb_pipe_ctrl_backend.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_backend_pkg.sv
// riscv_pkg: shared encodings and control-bundle types for the pipeline
// control backend (E/M/W control registers + hazard unit).
//   RESULT_*  : writeback source select encodings
//   FWD_*     : E-stage operand forward select encodings
//   ctrl_e_t  : full control bundle held in the E register
//   ctrl_m_t  : subset carried into M
//   ctrl_w_t  : subset carried into W
//   fwd_sel() : forward select for one E-stage source register
package riscv_pkg;

  localparam int CTRL_REG_AW = 5;
  localparam int CTRL_ALUC_W = 3;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef struct packed {
    logic                   RegWrite;
    logic [1:0]             ResultSrc;
    logic                   MemWrite;
    logic                   Branch;
    logic                   Jump;
    logic                   ALUSrc;
    logic [CTRL_ALUC_W-1:0] ALUControl;
    logic [CTRL_REG_AW-1:0] Rs1;
    logic [CTRL_REG_AW-1:0] Rs2;
    logic [CTRL_REG_AW-1:0] Rd;
  } ctrl_e_t;

  typedef struct packed {
    logic                   RegWrite;
    logic [1:0]             ResultSrc;
    logic                   MemWrite;
    logic [CTRL_REG_AW-1:0] Rd;
  } ctrl_m_t;

  typedef struct packed {
    logic                   RegWrite;
    logic [1:0]             ResultSrc;
    logic [CTRL_REG_AW-1:0] Rd;
  } ctrl_w_t;

  // M has priority over W because it holds the younger result; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [CTRL_REG_AW-1:0] rs,
    input logic                   regwritem,
    input logic [CTRL_REG_AW-1:0] rdm,
    input logic                   regwritew,
    input logic [CTRL_REG_AW-1:0] rdw
  );
    if (regwritem && (rdm != '0) && (rdm == rs))      return FWD_M;
    else if (regwritew && (rdw != '0) && (rdw == rs)) return FWD_W;
    else                                              return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_ctrl_backend_hazard_unit.sv
// hazard_unit: purely combinational hazard logic.
//   in : rs1d/rs2d (D sources), rs1e/rs2e/rde/resultsrce (E state),
//        regwritem/rdm (M state), regwritew/rdw (W state), pcsrce
//   out: forwardae/forwardbe, lwstall, stallf/stalld, flushd/flushe
module hazard_unit
  import riscv_pkg::*;
(
  input  logic [CTRL_REG_AW-1:0] rs1d,
  input  logic [CTRL_REG_AW-1:0] rs2d,
  input  logic [CTRL_REG_AW-1:0] rs1e,
  input  logic [CTRL_REG_AW-1:0] rs2e,
  input  logic [CTRL_REG_AW-1:0] rde,
  input  logic [1:0]             resultsrce,
  input  logic                   regwritem,
  input  logic [CTRL_REG_AW-1:0] rdm,
  input  logic                   regwritew,
  input  logic [CTRL_REG_AW-1:0] rdw,
  input  logic                   pcsrce,
  output logic [1:0]             forwardae,
  output logic [1:0]             forwardbe,
  output logic                   lwstall,
  output logic                   stallf,
  output logic                   stalld,
  output logic                   flushd,
  output logic                   flushe
);

  assign forwardae = fwd_sel(rs1e, regwritem, rdm, regwritew, rdw);
  assign forwardbe = fwd_sel(rs2e, regwritem, rdm, regwritew, rdw);

  assign lwstall = (resultsrce == RESULT_MEM) && (rde != '0) &&
                   ((rde == rs1d) || (rde == rs2d));

  // A taken branch/jump squashes the dependent instruction anyway, so the
  // flush overrides the load-use stall.
  assign stallf = lwstall & ~pcsrce;
  assign stalld = lwstall & ~pcsrce;
  assign flushd = pcsrce;
  assign flushe = lwstall | pcsrce;

endmodule

// File: rtl/pipe_ctrl_backend.sv
// pipe_ctrl_backend: carries D-stage control through the E/M/W control
// registers, resolves branches/jumps in E and drives forward/stall/flush.
//   in : clk, reset (sync, active-high), D-stage control + Rs1D/Rs2D/RdD, ZeroE
//   out: ALUSrcE, ALUControlE, PCSrcE, MemWriteM, RegWriteW, ResultSrcW, RdW,
//        ForwardAE/BE, StallF, StallD, FlushD
module pipe_ctrl_backend
  import riscv_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteD,
  input  logic [1:0]        ResultSrcD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              ALUSrcD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              ZeroE,
  output logic              ALUSrcE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              PCSrcE,
  output logic              MemWriteM,
  output logic              RegWriteW,
  output logic [1:0]        ResultSrcW,
  output logic [REG_AW-1:0] RdW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD
);

  ctrl_e_t d_ctrl, e_q;
  ctrl_m_t m_q;
  ctrl_w_t w_q;
  logic    flushe, lwstall;

  assign d_ctrl = '{RegWrite: RegWriteD, ResultSrc: ResultSrcD, MemWrite: MemWriteD,
                    Branch: BranchD, Jump: JumpD, ALUSrc: ALUSrcD,
                    ALUControl: ALUControlD, Rs1: Rs1D, Rs2: Rs2D, Rd: RdD};

  // E never stalls: on a load-use hazard it takes a bubble while IF/ID holds.
  always_ff @(posedge clk) begin
    if (reset || flushe) e_q <= '0;
    else                 e_q <= d_ctrl;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
      w_q <= '0;
    end else begin
      m_q <= '{RegWrite: e_q.RegWrite, ResultSrc: e_q.ResultSrc,
               MemWrite: e_q.MemWrite, Rd: e_q.Rd};
      w_q <= '{RegWrite: m_q.RegWrite, ResultSrc: m_q.ResultSrc, Rd: m_q.Rd};
    end
  end

  assign PCSrcE      = (ZeroE & e_q.Branch) | e_q.Jump;
  assign ALUSrcE     = e_q.ALUSrc;
  assign ALUControlE = e_q.ALUControl;
  assign MemWriteM   = m_q.MemWrite;
  assign RegWriteW   = w_q.RegWrite;
  assign ResultSrcW  = w_q.ResultSrc;
  assign RdW         = w_q.Rd;

  hazard_unit u_hazard (
    .rs1d      (Rs1D),
    .rs2d      (Rs2D),
    .rs1e      (e_q.Rs1),
    .rs2e      (e_q.Rs2),
    .rde       (e_q.Rd),
    .resultsrce(e_q.ResultSrc),
    .regwritem (m_q.RegWrite),
    .rdm       (m_q.Rd),
    .regwritew (w_q.RegWrite),
    .rdw       (w_q.Rd),
    .pcsrce    (PCSrcE),
    .forwardae (ForwardAE),
    .forwardbe (ForwardBE),
    .lwstall   (lwstall),
    .stallf    (StallF),
    .stalld    (StallD),
    .flushd    (FlushD),
    .flushe    (flushe)
  );

endmodule

// File: tb/tb_pipe_ctrl_backend.sv
// Bench for pipe_ctrl_backend: a table of per-cycle D inputs with hand-derived
// combinational expectations; registered outputs are checked through a
// scoreboard queue holding the expected E/M/W contents of the last 3 rows.
module tb_pipe_ctrl_backend;

  logic       clk = 1'b0;
  logic       reset;
  logic       RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD, ZeroE;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       ALUSrcE, PCSrcE, MemWriteM, RegWriteW, StallF, StallD, FlushD;
  logic [2:0] ALUControlE;
  logic [1:0] ResultSrcW, ForwardAE, ForwardBE;
  logic [4:0] RdW;

  always #5 clk = ~clk;

  pipe_ctrl_backend dut (
    .clk(clk), .reset(reset), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .PCSrcE(PCSrcE),
    .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RdW(RdW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
  );

  typedef struct {
    logic       rst, rw, mw, br, jp, as, z;
    logic [1:0] rs;
    logic [2:0] alu;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] fa, fb;
    logic       st, fl;
  } row_t;

  typedef struct {
    logic       as, mw, rw;
    logic [2:0] alu;
    logic [1:0] rs;
    logic [4:0] rd;
  } sb_t;

  row_t tbl[$];
  sb_t  sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cur_row = 0;

  function automatic row_t mk(int rst, int rw, int rs, int mw, int br, int jp,
                              int as, int alu, int rs1, int rs2, int rd, int z,
                              int fa, int fb, int st, int fl);
    row_t r;
    r.rst = rst[0]; r.rw = rw[0]; r.rs = rs[1:0]; r.mw = mw[0];
    r.br = br[0]; r.jp = jp[0]; r.as = as[0]; r.alu = alu[2:0];
    r.rs1 = rs1[4:0]; r.rs2 = rs2[4:0]; r.rd = rd[4:0]; r.z = z[0];
    r.fa = fa[1:0]; r.fb = fb[1:0]; r.st = st[0]; r.fl = fl[0];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0d want=%0d", name, cur_row, act, exp);
    end
  endtask

  task automatic drive(input row_t r);
    reset = r.rst; RegWriteD = r.rw; ResultSrcD = r.rs; MemWriteD = r.mw;
    BranchD = r.br; JumpD = r.jp; ALUSrcD = r.as; ALUControlD = r.alu;
    Rs1D = r.rs1; Rs2D = r.rs2; RdD = r.rd; ZeroE = r.z;
  endtask

  initial begin
    row_t r;
    sb_t  e;
    sb_t  zero_e;
    int   nstall;

    zero_e = '{as: 1'b0, mw: 1'b0, rw: 1'b0, alu: 3'd0, rs: 2'd0, rd: 5'd0};
    //               rst rw rs mw br jp as alu rs1 rs2 rd z   fa fb st fl
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  0,  0,  7, 0,  0, 0, 0, 0)); // reset w/ RegWriteD
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  0,  0,  7, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  1,  2,  5, 0,  0, 0, 0, 0)); // add x5
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1,  5,  3,  8, 0,  0, 0, 0, 0)); // sub x8, x5
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 2,  4,  0,  9, 0,  2, 0, 0, 0)); // M forward
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  8,  5, 10, 0,  0, 0, 0, 0)); // reader of x8
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  1, 0, 0, 0)); // W forward
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  1,  1,  0, 0,  0, 0, 0, 0)); // write x0
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 12, 0,  0, 0, 0, 0)); // read x0
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 13, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,  2,  0,  0, 0,  0, 0, 0, 0)); // lw x0
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 14, 0,  0, 0, 0, 0)); // no stall on x0
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0,  1,  0,  6, 0,  0, 0, 0, 0)); // lw x6
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  3,  6, 15, 0,  0, 0, 1, 0)); // use x6: stall
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  3,  6, 15, 0,  0, 0, 0, 0)); // held, bubble in E
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  0, 1, 0, 0)); // ForwardBE=01
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1,  1,  2,  0, 0,  0, 0, 0, 0)); // beq
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 16, 1,  0, 0, 0, 1)); // taken
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 17, 1,  0, 0, 0, 0)); // E zeroed
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1,  0,  0,  0, 0,  0, 0, 0, 0)); // beq
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 18, 0,  0, 0, 0, 0)); // not taken
    tbl.push_back(mk(0, 1, 2, 0, 0, 1, 0, 0,  0,  0,  1, 0,  0, 0, 0, 0)); // jal
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 19, 0,  0, 0, 0, 1)); // jump taken
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0,  0,  0,  7, 0,  0, 0, 0, 0)); // load+branch
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  7,  0, 20, 1,  0, 0, 0, 1)); // flush beats stall
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3,  0,  0, 21, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 21,  7,  0, 0,  0, 0, 0, 0)); // store
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0,  0,  0,  0, 0,  2, 0, 0, 0)); // store
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  0,  0, 22, 0,  0, 0, 0, 0)); // reset, store in M
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 21,  0, 23, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 23, 23, 23, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0,  0, 23, 0,  2, 2, 0, 0)); // both from M
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 23, 24,  0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  2, 0, 0, 0)); // M over W
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Pipeline is known-empty after one reset edge.
    r = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(r);
    for (int i = 0; i < 3; i++) sb.push_back(zero_e);
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      cur_row = i;
      r = tbl[i];
      drive(r);
      @(negedge clk);
      chk("ForwardAE",   int'(ForwardAE),   int'(r.fa));
      chk("ForwardBE",   int'(ForwardBE),   int'(r.fb));
      chk("StallF",      int'(StallF),      int'(r.st));
      chk("StallD",      int'(StallD),      int'(r.st));
      chk("FlushD",      int'(FlushD),      int'(r.fl));
      chk("PCSrcE",      int'(PCSrcE),      int'(r.fl));
      chk("ALUSrcE",     int'(ALUSrcE),     int'(sb[2].as));
      chk("ALUControlE", int'(ALUControlE), int'(sb[2].alu));
      chk("MemWriteM",   int'(MemWriteM),   int'(sb[1].mw));
      chk("RegWriteW",   int'(RegWriteW),   int'(sb[0].rw));
      chk("ResultSrcW",  int'(ResultSrcW),  int'(sb[0].rs));
      chk("RdW",         int'(RdW),         int'(sb[0].rd));
      void'(sb.pop_front());
      // A row killed on its way into E, or squashed by reset, reaches W as zeros.
      if (r.rst || r.st || r.fl) e = zero_e;
      else e = '{as: r.as, mw: r.mw, rw: r.rw, alu: r.alu, rs: r.rs, rd: r.rd};
      sb.push_back(e);
      if (r.rst) for (int k = 0; k < 3; k++) sb[k] = zero_e;
      @(posedge clk); #1;
    end

    // Load-use: count stalled cycles while the consumer waits in D.
    cur_row = tbl.size();
    drive(mk(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 6, 9, 0, 0, 0, 0, 0));
    nstall = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (!StallF) break;
      nstall++;
      @(posedge clk); #1;
    end
    chk("lw_stall_cycles", nstall, 1);
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("lw_fwd_b", int'(ForwardBE), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
